// File: rtl/clock_gate_ctrl_pkg.sv
// Shared definitions for the multi-channel clock gating controller.
//   state_e    : per-channel gate FSM encoding
//   cnt_width  : width needed to count 0..n active channels
package clock_gate_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_ON   = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  function automatic int unsigned cnt_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/clock_gate_ctrl_if.sv
// Request/status bundle between a clock consumer's controller and clock_gate_ctrl.
//   en, force_on  : per-channel clock request and override (master -> slave)
//   test_en       : scan enable, forces all gated clocks on (master -> slave)
//   hold_cycles   : idle hold-off applied when a request drops (master -> slave)
//   gclk          : gated clocks (slave -> master)
//   ch_active     : registered gate enable per channel (slave -> master)
//   num_active    : registered count of running channels (slave -> master)
interface clock_gate_ctrl_if
  import clock_gate_ctrl_pkg::*;
#(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned HOLD_W = 4
);

  localparam int unsigned CNT_W = cnt_width(NUM_CH);

  logic [NUM_CH-1:0] en;
  logic [NUM_CH-1:0] force_on;
  logic              test_en;
  logic [HOLD_W-1:0] hold_cycles;
  logic [NUM_CH-1:0] gclk;
  logic [NUM_CH-1:0] ch_active;
  logic [CNT_W-1:0]  num_active;

  modport master (
    output en, force_on, test_en, hold_cycles,
    input  gclk, ch_active, num_active
  );

  modport slave (
    input  en, force_on, test_en, hold_cycles,
    output gclk, ch_active, num_active
  );

endinterface

// File: rtl/clock_gate_ctrl_icg_cell.sv
// Latch-based integrated clock gate.
//   clk  : source clock
//   en   : functional gate enable (changes only after posedge clk)
//   te   : test enable, bypasses the functional enable
//   gclk : gated clock
// The latch is transparent only while clk is low, so the enable seen by the
// AND gate is frozen for the whole high phase and no runt pulse can form.
module icg_cell (
  input  logic clk,
  input  logic en,
  input  logic te,
  output logic gclk
);

  logic en_q;

  always_latch begin
    if (!clk) begin
      en_q <= en | te;
    end
  end

  assign gclk = clk & en_q;

endmodule

// File: rtl/clock_gate_ctrl.sv
// Multi-channel glitch-free clock gating controller.
//   clk    : free-running source clock
//   reset  : synchronous, active-high reset
//   bus    : request/status bundle (slave side), see clock_gate_ctrl_if
// Each channel runs an OFF/ON/HOLD FSM on req = en | force_on. When the request
// drops the channel stays on for hold_cycles further cycles, so short gaps in
// the request do not toggle the clock. The registered gate enable drives one
// icg_cell per channel; test_en forces every gclk to follow clk.
module clock_gate_ctrl
  import clock_gate_ctrl_pkg::*;
#(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned HOLD_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  clock_gate_ctrl_if.slave  bus
);

  localparam int unsigned CNT_W = cnt_width(NUM_CH);

  logic [NUM_CH-1:0] active_d;
  logic [NUM_CH-1:0] active_q;
  logic [NUM_CH-1:0] gclk;
  logic [CNT_W-1:0]  num_d;
  logic [CNT_W-1:0]  num_q;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    state_e            state_q;
    state_e            state_d;
    logic [HOLD_W-1:0] cnt_q;
    logic [HOLD_W-1:0] cnt_d;
    logic              req;

    assign req = bus.en[i] | bus.force_on[i];

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
        ST_OFF: begin
          if (req) begin
            state_d = ST_ON;
          end
        end
        ST_ON: begin
          if (!req) begin
            if (bus.hold_cycles == '0) begin
              state_d = ST_OFF;
            end else begin
              // hold_cycles is captured here only; later changes do not matter
              state_d = ST_HOLD;
              cnt_d   = bus.hold_cycles;
            end
          end
        end
        ST_HOLD: begin
          if (req) begin
            state_d = ST_ON;
            cnt_d   = '0;
          end else if (cnt_q == HOLD_W'(1)) begin
            state_d = ST_OFF;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - HOLD_W'(1);
          end
        end
        default: begin
          state_d = ST_OFF;
          cnt_d   = '0;
        end
      endcase
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        state_q <= ST_OFF;
        cnt_q   <= '0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
      end
    end

    // Registered as active_q, so ch_active tracks the state register exactly.
    assign active_d[i] = (state_d != ST_OFF);

    icg_cell u_icg (
      .clk  (clk),
      .en   (active_q[i]),
      .te   (bus.test_en),
      .gclk (gclk[i])
    );
  end

  always_comb begin
    num_d = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      num_d = num_d + CNT_W'(active_d[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      active_q <= '0;
      num_q    <= '0;
    end else begin
      active_q <= active_d;
      num_q    <= num_d;
    end
  end

  assign bus.gclk       = gclk;
  assign bus.ch_active  = active_q;
  assign bus.num_active = num_q;

endmodule

// File: tb/tb_clock_gate_ctrl.sv
`timescale 1ns / 1ps
module tb_clock_gate_ctrl;

  logic clk;
  logic reset;

  clock_gate_ctrl_if #(.NUM_CH(2), .HOLD_W(4)) bus ();

  clock_gate_ctrl #(.NUM_CH(2), .HOLD_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  // gclk pulse counters and high-time monitor
  int  pc0 = 0;
  int  pc1 = 0;
  int  runts = 0;
  int  hi_seen = 0;
  bit  mon_en = 1'b0;
  time rise0 = 0;
  time rise1 = 0;

  always @(posedge bus.gclk[0]) begin
    pc0++;
    rise0 = $time;
  end
  always @(posedge bus.gclk[1]) begin
    pc1++;
    rise1 = $time;
  end
  always @(negedge bus.gclk[0]) begin
    if (mon_en) begin
      hi_seen++;
      if ($time - rise0 != 5) runts++;
    end
  end
  always @(negedge bus.gclk[1]) begin
    if (mon_en) begin
      hi_seen++;
      if ($time - rise1 != 5) runts++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to 1ns after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  int base0;
  int base1;
  int n;

  initial begin
    // 1. reset with requests asserted
    reset           = 1'b1;
    bus.en          = 2'b11;
    bus.force_on    = 2'b00;
    bus.test_en     = 1'b0;
    bus.hold_cycles = 4'd0;
    tick();
    base0 = pc0;
    base1 = pc1;
    for (int i = 0; i < 3; i++) begin
      tick();
      #1;
      check("rst_gclk_high_phase", 32'(bus.gclk), 32'd0);
      check("rst_ch_active", 32'(bus.ch_active), 32'd0);
      check("rst_num_active", 32'(bus.num_active), 32'd0);
    end
    check("rst_pulses", 32'(pc0 - base0 + pc1 - base1), 32'd0);
    reset  = 1'b0;
    bus.en = 2'b00;
    tick();
    tick();
    check("post_rst_ch_active", 32'(bus.ch_active), 32'd0);

    // 2. hold 0, en[0] for three sampled edges
    bus.hold_cycles = 4'd0;
    bus.en          = 2'b01;
    base0 = pc0;
    base1 = pc1;
    tick();
    check("t2_act_e1", 32'(bus.ch_active), 32'b01);
    check("t2_pulses_e1", 32'(pc0 - base0), 32'd0);
    tick();
    check("t2_act_e2", 32'(bus.ch_active), 32'b01);
    check("t2_pulses_e2", 32'(pc0 - base0), 32'd1);
    tick();
    check("t2_act_e3", 32'(bus.ch_active), 32'b01);
    check("t2_pulses_e3", 32'(pc0 - base0), 32'd2);
    bus.en = 2'b00;
    tick();
    check("t2_act_off", 32'(bus.ch_active), 32'b00);
    check("t2_pulses_total", 32'(pc0 - base0), 32'd3);
    tick();
    check("t2_pulses_after", 32'(pc0 - base0), 32'd3);
    check("t2_ch1_idle", 32'(pc1 - base1), 32'd0);

    // 3. hold 3, en[1] for one edge
    bus.hold_cycles = 4'd3;
    bus.en          = 2'b10;
    base1 = pc1;
    tick();
    bus.en = 2'b00;
    n = 0;
    while (bus.ch_active[1] && n < 40) begin
      n++;
      tick();
    end
    check("t3_active_cycles", 32'(n), 32'd4);
    check("t3_pulses", 32'(pc1 - base1), 32'd4);
    tick();
    check("t3_off", 32'(bus.ch_active), 32'b00);
    check("t3_pulses_after", 32'(pc1 - base1), 32'd4);

    // 4. hold 5, request gap shorter than hold, then hold change mid-HOLD
    bus.hold_cycles = 4'd5;
    bus.en          = 2'b01;
    tick();
    check("t4_on", 32'(bus.ch_active), 32'b01);
    base0  = pc0;
    bus.en = 2'b00;
    tick();
    check("t4_gap1_act", 32'(bus.ch_active[0]), 32'd1);
    check("t4_gap1_pulses", 32'(pc0 - base0), 32'd1);
    tick();
    check("t4_gap2_act", 32'(bus.ch_active[0]), 32'd1);
    check("t4_gap2_pulses", 32'(pc0 - base0), 32'd2);
    bus.en = 2'b01;
    tick();
    check("t4_reon_act", 32'(bus.ch_active[0]), 32'd1);
    check("t4_reon_pulses", 32'(pc0 - base0), 32'd3);
    bus.en = 2'b00;
    tick();
    bus.hold_cycles = 4'd15;
    base0 = pc0;
    n = 0;
    while (bus.ch_active[0] && n < 40) begin
      n++;
      tick();
    end
    check("t4_hold_cycles", 32'(n), 32'd5);
    check("t4_hold_pulses", 32'(pc0 - base0), 32'd5);

    // 5. test_en forces gclk = clk under reset
    bus.en      = 2'b00;
    reset       = 1'b1;
    bus.test_en = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      #1;
      check("t5_gclk_high", 32'(bus.gclk), 32'b11);
      @(negedge clk);
      #1;
      check("t5_gclk_low", 32'(bus.gclk), 32'b00);
      check("t5_ch_active", 32'(bus.ch_active), 32'b00);
      tick();
    end
    bus.test_en = 1'b0;
    reset       = 1'b0;
    tick();
    tick();

    // 6. async en[0] toggles in the high phase with force_on[1]
    bus.hold_cycles = 4'd0;
    bus.force_on    = 2'b10;
    bus.en          = 2'b01;
    mon_en          = 1'b1;
    tick();
    check("t6_both_act", 32'(bus.ch_active), 32'b11);
    check("t6_num2", 32'(bus.num_active), 32'd2);
    for (int i = 0; i < 4; i++) begin
      #2 bus.en[0] = ~bus.en[0];
      #1 bus.test_en = 1'b1;
      #1 bus.test_en = 1'b0;
      tick();
      check("t6_num_toggle", 32'(bus.num_active), (i % 2 == 0) ? 32'd1 : 32'd2);
    end
    bus.force_on = 2'b00;
    bus.en       = 2'b00;
    tick();
    tick();
    mon_en = 1'b0;
    check("t6_num0", 32'(bus.num_active), 32'd0);
    check("t6_runts", 32'(runts), 32'd0);
    check("t6_pulses_seen", 32'(hi_seen >= 8), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
